// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared types and constants for the memory-stage SRAM controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int C_ADDR_BASE = 1024;
    localparam int C_SRAM_DW   = 16;
    localparam int C_SRAM_AW   = 18;

endpackage

`default_nettype wire

// File: rtl/wait_counter.sv
// ============================================================================
// Module : wait_counter
// Brief  : 4-bit up-counter with clear; o_last flags count == WAIT_CYCLES.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wait_counter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    localparam logic [3:0] C_LAST = 4'(WAIT_CYCLES);

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign o_last = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/sram_ctrl.sv
// ============================================================================
// Module : sram_ctrl
// Brief  : Splits each 32-bit load/store into two 16-bit SRAM accesses and
//          stalls the pipeline (ready low) until the access completes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_ctrl
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_BASE   = C_ADDR_BASE,
    parameter int SRAM_AW     = C_SRAM_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_r_en,
    input  logic                 mem_w_en,
    input  logic [31:0]          addr,
    input  logic [31:0]          wr_data,
    output logic [31:0]          rd_data,
    output logic                 ready,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic [C_SRAM_DW-1:0] sram_dq_out,
    input  logic [C_SRAM_DW-1:0] sram_dq_in,
    output logic                 sram_dq_oe,
    output logic                 sram_we_n
);

    state_t             r_state;
    state_t             w_next;
    logic [SRAM_AW-2:0] r_word;
    logic [31:0]        r_wdata;
    logic               r_write;
    logic [15:0]        r_rd_lo;
    logic [31:0]        r_rd_data;

    logic               w_req;
    logic               w_last;
    logic               w_clr;
    logic               w_cnt_en;
    logic [31:0]        w_offset;
    logic [SRAM_AW-2:0] w_word;
    logic               w_unused;

    assign w_req    = mem_r_en | mem_w_en;
    assign w_offset = addr - 32'(ADDR_BASE);
    // Byte-in-word bits are dropped and out-of-range offsets wrap modulo SRAM size.
    assign w_word   = w_offset[SRAM_AW:2];
    assign w_unused = ^{w_offset[31:SRAM_AW+1], w_offset[1:0]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req)  w_next = LOW;
            LOW:     if (w_last) w_next = HIGH;
            HIGH:    if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_clr    = (w_next != r_state);
    assign w_cnt_en = (r_state == LOW) || (r_state == HIGH);

    wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_en   (w_cnt_en),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_word    <= '0;
            r_wdata   <= 32'd0;
            r_write   <= 1'b0;
            r_rd_lo   <= 16'd0;
            r_rd_data <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_word  <= w_word;
                r_wdata <= wr_data;
                r_write <= mem_w_en;
            end
            // Read halves are sampled on the final cycle of each phase.
            if (!r_write && w_last) begin
                if (r_state == LOW) begin
                    r_rd_lo <= sram_dq_in;
                end else if (r_state == HIGH) begin
                    r_rd_data <= {sram_dq_in, r_rd_lo};
                end
            end
        end
    end

    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (r_state)
            LOW: begin
                sram_addr = {r_word, 1'b0};
                if (r_write) begin
                    sram_dq_out = r_wdata[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
            end
            HIGH: begin
                sram_addr = {r_word, 1'b1};
                if (r_write) begin
                    sram_dq_out = r_wdata[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign ready   = ((r_state == IDLE) && !w_req) || (r_state == DONE);
    assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_sram_ctrl.sv
// ============================================================================
// Module : tb_sram_ctrl
// Brief  : Self-checking bench for sram_ctrl with an SRAM pin model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_ctrl;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic [31:0] addr = 32'd0, wr_data = 32'd0;
    logic [31:0] rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in = 16'd0;
    logic        sram_dq_oe, sram_we_n;

    logic        r0_en = 1'b0;
    logic [31:0] addr0 = 32'd0;
    logic [31:0] rd_data0;
    logic        ready0;
    logic [17:0] sram_addr0;
    logic [15:0] sram_dq_out0;
    logic [15:0] sram_dq_in0;
    logic        sram_dq_oe0, sram_we_n0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(1024), .SRAM_AW(18)) u_dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
        .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    sram_ctrl #(.WAIT_CYCLES(0), .ADDR_BASE(1024), .SRAM_AW(18)) u_dut0 (
        .clk(clk), .rst(rst), .mem_r_en(r0_en), .mem_w_en(1'b0),
        .addr(addr0), .wr_data(32'd0), .rd_data(rd_data0), .ready(ready0),
        .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0), .sram_dq_in(sram_dq_in0),
        .sram_dq_oe(sram_dq_oe0), .sram_we_n(sram_we_n0)
    );

    assign sram_dq_in0 = 16'hA5A5 ^ sram_addr0[15:0];

    // Pin-level SRAM: a halfword commits only after WE_n is held low on one
    // address for W+1 cycles; reference memory tracks intended contents.
    logic [15:0] sram    [int];
    logic [15:0] ref_mem [int];
    logic [31:0] ref_rd = 32'd0;
    int          wr_run = 0;
    logic [17:0] wr_a   = 18'd0;

    function automatic logic [15:0] sram_get(int k);
        return sram.exists(k) ? sram[k] : 16'h0;
    endfunction

    function automatic logic [15:0] ref_get(int k);
        return ref_mem.exists(k) ? ref_mem[k] : 16'h0;
    endfunction

    always @(negedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            if (wr_run > 0 && sram_addr == wr_a) wr_run = wr_run + 1;
            else wr_run = 1;
            wr_a = sram_addr;
            if (wr_run == W + 1) sram[int'(sram_addr)] = sram_dq_out;
        end else begin
            wr_run = 0;
        end
        sram_dq_in = sram_get(int'(sram_addr));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic preload(input int k, input logic [15:0] v);
        sram[k]    = v;
        ref_mem[k] = v;
    endtask

    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        int unsigned word;
        int hw, k, we_cyc;
        word = ((a - 32'd1024) >> 2) & 32'h1FFFF;
        hw   = int'(word) * 2;
        @(negedge clk);
        mem_r_en = r; mem_w_en = w; addr = a; wr_data = d;
        #1 chk("req_ready", 32'(ready), 32'd0);
        k = 0; we_cyc = 0;
        forever begin
            @(posedge clk); #1;
            if (ready) break;
            k++;
            if (!hold) begin mem_r_en = 1'b0; mem_w_en = 1'b0; end
            if (!sram_we_n) we_cyc++;
            chk("hw_addr", 32'(sram_addr), 32'((k <= W + 1) ? hw : hw + 1));
            if (w) chk("dq_out", 32'(sram_dq_out), 32'((k <= W + 1) ? d[15:0] : d[31:16]));
            else   chk("rd_oe", 32'(sram_dq_oe), 32'd0);
            if (k > 40) begin chk("timeout", 32'(k), 32'd0); break; end
        end
        chk("stall", 32'(k + 1), 32'(1 + 2 * (W + 1)));
        chk("we_cycles", 32'(we_cyc), w ? 32'(2 * (W + 1)) : 32'd0);
        if (w) begin
            ref_mem[hw]     = d[15:0];
            ref_mem[hw + 1] = d[31:16];
        end else begin
            ref_rd = {ref_get(hw + 1), ref_get(hw)};
        end
        chk("rd_data", rd_data, ref_rd);
        @(posedge clk); #1;
        if (hold) begin mem_r_en = 1'b0; mem_w_en = 1'b0; #1; end
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_we_n", 32'(sram_we_n), 32'd1);
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        bit          hold;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int k;
        tbl[0] = '{1'b1, 1'b0, 32'd1028, 32'd0,          1'b0, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 1'b1, 32'd1032, 32'h12345678,   1'b0, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b0, 32'd1032, 32'd0,          1'b0, 32'h12345678};
        tbl[3] = '{1'b1, 1'b0, 32'd1028, 32'd0,          1'b1, 32'hDEADBEEF};
        tbl[4] = '{1'b1, 1'b1, 32'd1036, 32'hCAFEF00D,   1'b0, 32'hDEADBEEF};
        tbl[5] = '{1'b1, 1'b0, 32'd1036, 32'd0,          1'b0, 32'hCAFEF00D};
        tbl[6] = '{1'b1, 1'b0, 32'd1035, 32'd0,          1'b0, 32'h12345678};
        tbl[7] = '{1'b0, 1'b1, 32'd1028, 32'h0F0F0F0F,   1'b1, 32'h12345678};

        preload(2, 16'hBEEF);
        preload(3, 16'hDEAD);
        preload(9, 16'h0BAD);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",   32'(ready),       32'd1);
        chk("rst_rd_data", rd_data,          32'd0);
        chk("rst_addr",    32'(sram_addr),   32'd0);
        chk("rst_dq_out",  32'(sram_dq_out), 32'd0);
        chk("rst_oe",      32'(sram_dq_oe),  32'd0);
        chk("rst_we_n",    32'(sram_we_n),   32'd1);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            access(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].hold);
            chk("tbl_rd", rd_data, tbl[i].exp_rd);
        end

        // Reset during the first HIGH cycle of a write to word 4 (halfwords 8/9).
        @(negedge clk);
        mem_w_en = 1'b1; addr = 32'd1040; wr_data = 32'h55667788;
        k = 0;
        forever begin
            @(posedge clk); #1;
            k++;
            mem_w_en = 1'b0;
            if (k == W + 2 || k > 40) break;
        end
        chk("pre_rst_addr", 32'(sram_addr), 32'd9);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_we_n",  32'(sram_we_n),  32'd1);
        chk("mid_rst_oe",    32'(sram_dq_oe), 32'd0);
        chk("mid_rst_rd",    rd_data,         32'd0);
        chk("mid_rst_addr",  32'(sram_addr),  32'd0);
        chk("mid_rst_ready", 32'(ready),      32'd1);
        rst = 1'b0;
        ref_mem[8] = 16'h7788;
        ref_rd     = 32'd0;
        access(1'b1, 1'b0, 32'd1040, 32'd0, 1'b0);
        chk("abandoned_hi", rd_data, 32'h0BAD7788);

        // WAIT_CYCLES=0 instance, misaligned address 1027 maps to word 0.
        @(negedge clk);
        r0_en = 1'b1; addr0 = 32'd1027;
        #1 chk("w0_req_ready", 32'(ready0), 32'd0);
        k = 0;
        forever begin
            @(posedge clk); #1;
            if (ready0) break;
            k++;
            r0_en = 1'b0;
            chk("w0_hw_addr", 32'(sram_addr0), (k == 1) ? 32'd0 : 32'd1);
            if (k > 40) break;
        end
        chk("w0_stall", 32'(k + 1), 32'd3);
        chk("w0_rd", rd_data0, 32'hA5A4A5A5);

        for (int i = 0; i < 40; i++) begin
            logic        rr, ww;
            logic [31:0] aa;
            if ($urandom_range(0, 1) == 0) begin rr = 1'b1; ww = 1'b0; end
            else begin ww = 1'b1; rr = 1'($urandom_range(0, 1)); end
            if ($urandom_range(0, 7) == 0)
                aa = 32'd1024 - 32'(4 * $urandom_range(1, 3)) + 32'($urandom_range(0, 3));
            else
                aa = 32'd1024 + 32'($urandom_range(0, 63));
            access(rr, ww, aa, $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_ctrl.md
# sram_ctrl

Memory-stage controller sitting directly downstream of the EXE-stage pipeline register. It consumes that register's memory enables, ALU result (address) and Rm value (store data), and performs each 32-bit load/store as two 16-bit accesses on an external SRAM. While an access is in progress it holds `ready` low, which the hazard/freeze logic uses to stall every upstream pipeline register. On completion it presents load data to the MEM/WB register.

## Interface
Parameters:
- `WAIT_CYCLES`, 1: extra cycles held per 16-bit half access (0..15).
- `ADDR_BASE`, 1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, 18: SRAM halfword address width.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset is synchronous and active-high.
- `mem_r_en`  in  1  load request, from EXE register.
- `mem_w_en`  in  1  store request, from EXE register.
- `addr`  in  32  byte address (ALU result).
- `wr_data`  in  32  store data (Rm value).
- `rd_data`  out  32  load data, registered.
- `ready`  out  1  low = stall pipeline.
- `sram_addr`  out  SRAM_AW  halfword address.
- `sram_dq_out`  out  16  write data to pad.
- `sram_dq_in`  in  16  read data from pad.
- `sram_dq_oe`  out  1  pad output enable (write).
- `sram_we_n`  out  1  SRAM write strobe, active-low.

## Operation
- Word index = (`addr` − `ADDR_BASE`) >> 2, truncated to SRAM_AW−1 bits (modulo wrap for out-of-range addresses). `addr[1:0]` is ignored.
- States:
  - IDLE: no access in progress.
  - LOW: low halfword access. `sram_addr` = {word, 1'b0}.
  - HIGH: high halfword access. `sram_addr` = {word, 1'b1}.
  - DONE: access complete.
- IDLE → LOW when `mem_r_en | mem_w_en`. Address, data and operation are latched on this edge. If both enables are high, the access is a write.
- LOW → HIGH and HIGH → DONE after WAIT_CYCLES+1 cycles in the state, counted by a wait counter that is cleared on every state entry.
- DONE → IDLE unconditionally. Enables still high in DONE belong to the finishing instruction and never retrigger.
- Write:
  - `sram_dq_oe`=1 and `sram_we_n`=0 throughout LOW and HIGH.
  - `sram_dq_out` = `wr_data[15:0]` in LOW and `wr_data[31:16]` in HIGH.
- Read:
  - `sram_dq_oe`=0 and `sram_we_n`=1.
  - `sram_dq_in` is captured on the last cycle of LOW into bits [15:0] and on the last cycle of HIGH into bits [31:16].
  - `rd_data` updates only on read completion and holds otherwise.
- `ready` (combinational) = (IDLE & ~(`mem_r_en` | `mem_w_en`)) | DONE.

## Timing
- Reset (sampled at edge): state IDLE, counter 0, `rd_data`=0, `sram_addr`=0, `sram_dq_out`=0, `sram_dq_oe`=0, `sram_we_n`=1.
- After reset, `ready`=1 whenever no request is present.
- Request arrives in cycle 0: `ready`=0 in cycle 0. `ready` stays low for 1+2·(WAIT_CYCLES+1) cycles, then is 1 for exactly one cycle (DONE). The pipeline advances on that edge.
  - WAIT_CYCLES=1: 5 stall cycles.
  - WAIT_CYCLES=0: 3 stall cycles.
- `rd_data` is valid in DONE and stays stable until the next read completes.
- Back-to-back accesses: a new request seen in the IDLE cycle after DONE starts immediately. There is one idle cycle between accesses; its `ready` is 0 because the request is present.
- Reset mid-access: the next edge forces IDLE, deasserts `sram_we_n`/`sram_dq_oe`, and abandons any partial write. `rd_data` returns to 0.

## Structure
- Shared package `mem_pkg` holds:
  - State enum: IDLE=2'd0, LOW=2'd1, HIGH=2'd2, DONE=2'd3.
  - Default `ADDR_BASE`.
  - SRAM data width 16 and address width 18.
- One natural sub-module: `wait_counter`, a 4-bit up-counter with clear and a `last` flag (count == WAIT_CYCLES), instantiated once.
- Pad tristate lives at the top level, not in this block.

## Test plan
- Read, WAIT_CYCLES=1: preload SRAM halfwords 2→0xBEEF and 3→0xDEAD, then pulse read at `addr`=1028. Required: `ready` low 5 cycles, `sram_addr` 2 then 3, `rd_data`=0xDEADBEEF in DONE.
- Write then read: store 0x12345678 to 1032. Required: `sram_we_n` low 4 cycles, `sram_dq_out` 0x5678 at halfword 4 then 0x1234 at halfword 5. A subsequent load from 1032 returns 0x12345678.
- WAIT_CYCLES=0, `addr` bits [1:0]=2'b11 at 1027: required `ready` low 3 cycles, and the access uses word 0 (halfwords 0/1).
- Enables held high through DONE, then dropped: required exactly one access, with `ready` returning to 1 in IDLE.
- Both enables high: required write behaviour, and `rd_data` unchanged.
- `rst` asserted during HIGH of a write: required next edge `sram_we_n`=1, `sram_dq_oe`=0, state IDLE, `rd_data`=0, and halfword 1 of that word unwritten.
